seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal minimum 2.
REQ-003 Parameter HEX_MODE, default 0; 0 selects BCD decode, 1 selects hex decode (A-F glyphs).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 load  input  1  one-cycle strobe that captures value.
REQ-007 value  input  4*N_DIGITS  packed nibbles; nibble 0 (bits 3:0) is the rightmost digit.
REQ-008 lz_blank_en  input  1  leading-zero blanking enable, sampled every cycle.
REQ-009 seg  output  7  {a,b,c,d,e,f,g}, active low (0 = segment lit), registered.
REQ-010 an  output  N_DIGITS  digit enables, one-hot active low, registered.
REQ-011 bcd_err  output  1  high while the displayed word holds a nibble >9 with HEX_MODE=0; registered.

Function
REQ-012 Prescaler counts 0..REFRESH_DIV-1 and wraps; tick asserts for one cycle at count REFRESH_DIV-1.
REQ-013 Digit index advances on tick, N_DIGITS-1 wraps to 0; frame boundary = tick with index N_DIGITS-1.
REQ-014 load writes value into shadow register on the same edge.
REQ-015 At a frame boundary, display register takes shadow; if load coincides with the boundary, display register takes value directly.
REQ-016 Display register changes only at frame boundaries (no tearing within a frame).
REQ-017 seg/an reflect the current index with exactly one cycle latency after index change.
REQ-018 an drives 0 only on bit [index]; all other bits 1.
REQ-019 Glyphs: 0=0000001,1=1001111,2=0010010,3=0000110,4=1001100,5=0100100,6=0100000,7=0001111,8=0000000,9=0000100; hex A=0001000,b=1100000,C=0110001,d=1000010,E=0110000,F=0111000.
REQ-020 HEX_MODE=0, nibble >9: seg = 1111110 (dash).
REQ-021 Leading-zero blanking: with lz_blank_en=1, a zero digit above the most-significant nonzero digit outputs 1111111; digit 0 never blanked.
REQ-022 bcd_err updates one cycle after the display register changes; constant 0 when HEX_MODE=1.

Reset
REQ-023 rst_n=0 at an edge: prescaler 0, index 0, shadow 0, display 0, seg 1111111, an all 1, bcd_err 0.
REQ-024 Reset mid-frame or coincident with load discards load; scanning restarts at digit 0 on the first edge after release.

Configuration
REQ-025 Macro SEG7_BLINK_EN defined: adds input blink [N_DIGITS-1:0] and parameter BLINK_FRAMES (default 64); blink phase toggles every BLINK_FRAMES frame boundaries, resets to "on"; in "off" phase digits with blink bit set output 1111111.
REQ-026 Macro undefined: no blink port, no phase counter, behaviour per REQ-012..022 only.

Structure
REQ-027 Package seg7_pkg holds glyph constants (0-F, dash, blank) and the segment bit-order definition.
REQ-028 Combinational nibble-to-glyph decode lives in sub-module seg7_glyph_dec (nibble, hex_mode -> seg); one instance.

Verification (REFRESH_DIV=4, N_DIGITS=4, HEX_MODE=0)
REQ-029 Reset then idle -> seg=1111111, an=1111 during reset; after release an cycles 1110,1101,1011,0111 every 4 cycles, seg=0000001.
REQ-030 load value=16'h1234 mid-frame -> old digits until boundary, then digit0 seg=1001100, digit3 seg=1001111.
REQ-031 load at exact boundary cycle with 16'h0987 -> new frame shows 0987 immediately; lz_blank_en=1 -> digit3 seg=1111111.
REQ-032 load 16'h00A0 -> digit1 seg=1111110, bcd_err=1 one cycle after transfer; HEX_MODE=1 rerun -> digit1 seg=0001000, bcd_err=0.
REQ-033 lz_blank_en=1, value 16'h0000 -> digits 3..1 blank, digit0 seg=0000001.
REQ-034 SEG7_BLINK_EN, BLINK_FRAMES=2, blink=4'b0001 -> digit0 blank on alternate 2-frame windows; other digits unaffected.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit order and
// active-low glyph patterns (0 = segment lit).
package seg7_pkg;

    // Segment vector bit order, MSB first: {a,b,c,d,e,f,g}
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_bits_t;

    typedef logic [6:0] seg_t;

    localparam seg_t GLYPH_0     = 7'b0000001;
    localparam seg_t GLYPH_1     = 7'b1001111;
    localparam seg_t GLYPH_2     = 7'b0010010;
    localparam seg_t GLYPH_3     = 7'b0000110;
    localparam seg_t GLYPH_4     = 7'b1001100;
    localparam seg_t GLYPH_5     = 7'b0100100;
    localparam seg_t GLYPH_6     = 7'b0100000;
    localparam seg_t GLYPH_7     = 7'b0001111;
    localparam seg_t GLYPH_8     = 7'b0000000;
    localparam seg_t GLYPH_9     = 7'b0000100;
    localparam seg_t GLYPH_A     = 7'b0001000;
    localparam seg_t GLYPH_B     = 7'b1100000;
    localparam seg_t GLYPH_C     = 7'b0110001;
    localparam seg_t GLYPH_D     = 7'b1000010;
    localparam seg_t GLYPH_E     = 7'b0110000;
    localparam seg_t GLYPH_F     = 7'b0111000;
    localparam seg_t GLYPH_DASH  = 7'b1111110;
    localparam seg_t GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational nibble-to-glyph decoder; in BCD mode nibbles above 9 show a dash.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output seg_t       seg
);

    always_comb begin
        seg = GLYPH_DASH;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = GLYPH_DASH;
        endcase
        if (!hex_mode && nibble > 4'd9) begin
            seg = GLYPH_DASH;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow/display double buffering.
// Define SEG7_BLINK_EN to add the per-digit blink input and BLINK_FRAMES parameter.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX_MODE    = 0
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  lz_blank_en,
`ifdef SEG7_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink,
`endif
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  bcd_err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PW-1:0]             presc;
    logic [IW-1:0]             idx;
    logic [N_DIGITS-1:0][3:0]  shadow;
    logic [N_DIGITS-1:0][3:0]  disp;
    logic                      tick;
    logic                      frame_end;
    logic                      upper_zero;
    logic                      digit_blank;
    logic                      has_bad;
    logic                      blink_blank;
    seg_t                      dec_seg;

    assign tick      = (presc == PW'(REFRESH_DIV - 1));
    assign frame_end = tick && (idx == IW'(N_DIGITS - 1));

    // The display word only moves at frame ends, so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            idx    <= '0;
            shadow <= '0;
            disp   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= frame_end ? '0 : idx + 1'b1;
            end
            if (load) begin
                shadow <= value;
            end
            if (frame_end) begin
                disp <= load ? value : shadow;
            end
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        has_bad    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx) && disp[i] != 4'd0) begin
                upper_zero = 1'b0;
            end
            if (disp[i] > 4'd9) begin
                has_bad = 1'b1;
            end
        end
        digit_blank = lz_blank_en && (idx != '0) && upper_zero;
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] frame_cnt;
    logic          blink_on;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == BW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_blank = !blink_on && blink[idx];
`else
    assign blink_blank = 1'b0;
`endif

    seg7_glyph_dec u_dec (
        .nibble   (disp[idx]),
        .hex_mode (HEX_MODE != 0),
        .seg      (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg     <= GLYPH_BLANK;
            an      <= '1;
            bcd_err <= 1'b0;
        end else begin
            seg     <= (digit_blank || blink_blank) ? GLYPH_BLANK : dec_seg;
            an      <= ~(N_DIGITS'(1) << idx);
            bcd_err <= (HEX_MODE == 0) && has_bad;
        end
    end

endmodule
